// File: rtl/sme_job_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sme_job_sequencer_if
//  Description : Host, engine and result signal bundle for the SME job
//                sequencer. The sequencer is the slave; the host/engine side
//                (or a testbench) is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sme_job_sequencer_if;
    // host load / control
    logic [7:0] host_char;
    logic       host_str_wr;
    logic       host_pat_wr;
    logic       host_pat_end;
    logic       host_start;
    logic       busy;
    // engine drive
    logic [7:0] eng_chardata;
    logic       eng_isstring;
    logic       eng_ispattern;
    // engine result
    logic       eng_valid;
    logic       eng_match;
    logic [4:0] eng_index;
    // host result
    logic       res_valid;
    logic       res_match;
    logic [4:0] res_index;
    logic [1:0] res_id;
    logic       res_timeout;
    logic       done;

    modport slave (
        input  host_char, host_str_wr, host_pat_wr, host_pat_end, host_start,
        input  eng_valid, eng_match, eng_index,
        output busy, eng_chardata, eng_isstring, eng_ispattern,
        output res_valid, res_match, res_index, res_id, res_timeout, done
    );

    modport master (
        output host_char, host_str_wr, host_pat_wr, host_pat_end, host_start,
        output eng_valid, eng_match, eng_index,
        input  busy, eng_chardata, eng_isstring, eng_ispattern,
        input  res_valid, res_match, res_index, res_id, res_timeout, done
    );
endinterface
`default_nettype wire

// File: rtl/sme_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sme_job_sequencer
//  Description : Buffers one target string and a small queue of patterns,
//                replays string+pattern into the string-matching engine once
//                per pattern, and reports each result (or a watchdog timeout)
//                tagged with the pattern slot id.
//  Revision    : 1.0 - initial release
// ============================================================================
module sme_job_sequencer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int NPAT    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    sme_job_sequencer_if.slave bus
);

    localparam int STR_LW = $clog2(STR_MAX + 1);   // string length width
    localparam int STR_AW = $clog2(STR_MAX);       // string address width
    localparam int PAT_LW = $clog2(PAT_MAX + 1);   // pattern length width
    localparam int PAT_AW = $clog2(PAT_MAX);       // pattern address width
    localparam int ID_W   = $clog2(NPAT);          // slot id width
    localparam int CNT_W  = $clog2(NPAT + 1);      // slot count width

    localparam logic [STR_LW-1:0] C_STR_MAX = STR_LW'(STR_MAX);
    localparam logic [PAT_LW-1:0] C_PAT_MAX = PAT_LW'(PAT_MAX);
    localparam logic [CNT_W-1:0]  C_NPAT    = CNT_W'(NPAT);
    localparam logic [7:0]        C_TIMEOUT = 8'(TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEND_STR = 3'd1;
    localparam logic [2:0] S_GAP1     = 3'd2;
    localparam logic [2:0] S_SEND_PAT = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_REPORT   = 3'd5;
    localparam logic [2:0] S_GAP2     = 3'd6;
    localparam logic [2:0] S_FIN      = 3'd7;

    // buffers (no reset: validity is tracked by the length registers)
    logic [7:0]        r_str_mem [STR_MAX];
    logic [7:0]        r_pat_mem [NPAT][PAT_MAX];
    logic [PAT_LW-1:0] r_pat_len [NPAT];

    logic [2:0]        r_state;
    logic [STR_LW-1:0] r_str_len;
    logic [CNT_W-1:0]  r_pat_cnt;
    logic [PAT_LW-1:0] r_cur_len;
    logic [STR_AW-1:0] r_idx;
    logic [ID_W-1:0]   r_k;
    logic [7:0]        r_wait_cnt;

    logic              r_busy;
    logic [7:0]        r_eng_chardata;
    logic              r_eng_isstring;
    logic              r_eng_ispattern;
    logic              r_res_valid;
    logic              r_res_match;
    logic [4:0]        r_res_index;
    logic [ID_W-1:0]   r_res_id;
    logic              r_res_timeout;
    logic              r_done;

    logic              w_load;
    logic              w_str_ok;
    logic              w_pat_room;
    logic              w_pat_ok;
    logic [PAT_LW-1:0] w_cur_eff;
    logic              w_end_ok;
    logic [STR_AW-1:0] w_idx_inc;
    logic              w_str_last;
    logic              w_pat_last;
    logic              w_job_last;

    // Load qualification: only in IDLE, and a start in the same cycle takes
    // precedence so the buffers never change under a starting sequence.
    always_comb begin
        w_load     = !reset && (r_state == S_IDLE) && !bus.host_start;
        w_str_ok   = w_load && bus.host_str_wr && (r_str_len < C_STR_MAX);
        w_pat_room = (r_pat_cnt < C_NPAT);
        w_pat_ok   = w_load && bus.host_pat_wr && !bus.host_str_wr && w_pat_room &&
                     (r_cur_len < C_PAT_MAX);
        w_cur_eff  = r_cur_len + PAT_LW'(w_pat_ok);
        w_end_ok   = w_load && bus.host_pat_end && w_pat_room && (w_cur_eff != '0);
        w_idx_inc  = r_idx + STR_AW'(1);
        w_str_last = (STR_LW'(r_idx) == r_str_len - STR_LW'(1));
        w_pat_last = (STR_LW'(r_idx) == STR_LW'(r_pat_len[r_k]) - STR_LW'(1));
        w_job_last = (CNT_W'(r_k) + CNT_W'(1) == r_pat_cnt);
    end

    // Buffer writes for string chars, pattern chars and closed pattern lengths.
    always_ff @(posedge clk) begin
        if (w_str_ok) begin
            r_str_mem[r_str_len[STR_AW-1:0]] <= bus.host_char;
        end
        if (w_pat_ok) begin
            r_pat_mem[r_pat_cnt[ID_W-1:0]][r_cur_len[PAT_AW-1:0]] <= bus.host_char;
        end
        if (w_end_ok) begin
            r_pat_len[r_pat_cnt[ID_W-1:0]] <= w_cur_eff;
        end
    end

    // Sequencer FSM with registered engine/result outputs and load counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_str_len       <= '0;
            r_pat_cnt       <= '0;
            r_cur_len       <= '0;
            r_idx           <= '0;
            r_k             <= '0;
            r_wait_cnt      <= '0;
            r_busy          <= 1'b0;
            r_eng_chardata  <= '0;
            r_eng_isstring  <= 1'b0;
            r_eng_ispattern <= 1'b0;
            r_res_valid     <= 1'b0;
            r_res_match     <= 1'b0;
            r_res_index     <= '0;
            r_res_id        <= '0;
            r_res_timeout   <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.host_start) begin
                        if (r_str_len == '0 || r_pat_cnt == '0) begin
                            // nothing to run: finish straight away
                            r_state   <= S_FIN;
                            r_done    <= 1'b1;
                            r_str_len <= '0;
                            r_pat_cnt <= '0;
                            r_cur_len <= '0;
                        end else begin
                            r_state        <= S_SEND_STR;
                            r_busy         <= 1'b1;
                            r_k            <= '0;
                            r_idx          <= '0;
                            r_eng_isstring <= 1'b1;
                            r_eng_chardata <= r_str_mem[STR_AW'(0)];
                        end
                    end else begin
                        if (w_str_ok) begin
                            r_str_len <= r_str_len + STR_LW'(1);
                        end
                        if (w_end_ok) begin
                            r_pat_cnt <= r_pat_cnt + CNT_W'(1);
                            r_cur_len <= '0;
                        end else if (w_pat_ok) begin
                            r_cur_len <= w_cur_eff;
                        end
                    end
                end
                S_SEND_STR: begin
                    if (w_str_last) begin
                        r_state        <= S_GAP1;
                        r_eng_isstring <= 1'b0;
                        r_eng_chardata <= '0;
                    end else begin
                        r_idx          <= w_idx_inc;
                        r_eng_chardata <= r_str_mem[w_idx_inc];
                    end
                end
                S_GAP1: begin
                    // the engine latches the string on this falling edge
                    r_state         <= S_SEND_PAT;
                    r_idx           <= '0;
                    r_eng_ispattern <= 1'b1;
                    r_eng_chardata  <= r_pat_mem[r_k][PAT_AW'(0)];
                end
                S_SEND_PAT: begin
                    if (w_pat_last) begin
                        r_state         <= S_WAIT;
                        r_eng_ispattern <= 1'b0;
                        r_eng_chardata  <= '0;
                        r_wait_cnt      <= '0;
                    end else begin
                        r_idx          <= w_idx_inc;
                        r_eng_chardata <= r_pat_mem[r_k][w_idx_inc[PAT_AW-1:0]];
                    end
                end
                S_WAIT: begin
                    // a real result beats the watchdog in the same cycle
                    if (bus.eng_valid) begin
                        r_state       <= S_REPORT;
                        r_res_valid   <= 1'b1;
                        r_res_match   <= bus.eng_match;
                        r_res_index   <= bus.eng_match ? bus.eng_index : 5'd0;
                        r_res_id      <= r_k;
                        r_res_timeout <= 1'b0;
                    end else if (r_wait_cnt == C_TIMEOUT) begin
                        r_state       <= S_REPORT;
                        r_res_valid   <= 1'b1;
                        r_res_match   <= 1'b0;
                        r_res_index   <= '0;
                        r_res_id      <= r_k;
                        r_res_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_REPORT: begin
                    r_state       <= S_GAP2;
                    r_res_match   <= 1'b0;
                    r_res_index   <= '0;
                    r_res_id      <= '0;
                    r_res_timeout <= 1'b0;
                end
                S_GAP2: begin
                    if (w_job_last) begin
                        r_state   <= S_FIN;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_str_len <= '0;
                        r_pat_cnt <= '0;
                        r_cur_len <= '0;
                    end else begin
                        r_state        <= S_SEND_STR;
                        r_k            <= r_k + ID_W'(1);
                        r_idx          <= '0;
                        r_eng_isstring <= 1'b1;
                        r_eng_chardata <= r_str_mem[STR_AW'(0)];
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.eng_chardata  = r_eng_chardata;
    assign bus.eng_isstring  = r_eng_isstring;
    assign bus.eng_ispattern = r_eng_ispattern;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_match     = r_res_match;
    assign bus.res_index     = r_res_index;
    assign bus.res_id        = r_res_id;
    assign bus.res_timeout   = r_res_timeout;
    assign bus.done          = r_done;

endmodule
`default_nettype wire

// File: doc/sme_job_sequencer.md
Name: sme_job_sequencer

Overview:
- Host-side controller for the string-matching engine (SME).
- Buffers one target string (≤32 chars) and a queue of up to 4 patterns (≤8 chars each).
- On start, replays string + pattern into the engine once per queued pattern, collects each valid/match/index result, and reports it with the pattern id.
- Guards every job with a watchdog timeout so a hung engine cannot stall the host.

Parameters:
- STR_MAX, 32, string buffer depth in chars
- PAT_MAX, 8, max chars per pattern
- NPAT, 4, pattern queue depth
- TIMEOUT, 255, max cycles in WAIT before the job is aborted

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- host_char  in  8  char for string/pattern write
- host_str_wr  in  1  append host_char to string buffer
- host_pat_wr  in  1  append host_char to current pattern slot
- host_pat_end  in  1  close current pattern slot; may coincide with host_pat_wr, and then that char is included
- host_start  in  1  begin job sequence
- busy  out  1  sequence in progress
- eng_chardata  out  8  to engine chardata
- eng_isstring  out  1  to engine isstring
- eng_ispattern  out  1  to engine ispattern
- eng_valid  in  1  engine result strobe
- eng_match  in  1  engine match flag
- eng_index  in  5  engine match index
- res_valid  out  1  one-cycle result strobe
- res_match  out  1  pattern matched
- res_index  out  5  match index, 0 if no match or timeout
- res_id  out  2  pattern slot id of the result
- res_timeout  out  1  result produced by watchdog
- done  out  1  one-cycle pulse after last result

Behaviour:
- Clock and reset: single clock `clk`; synchronous active-high `reset`. All outputs are registered.
- Reset values: all outputs 0; str_len=0; pat_cnt=0; cur_len=0; state IDLE. Reset mid-sequence aborts immediately, with no further engine or host strobes.
- Loading (IDLE only; writes while busy=1 are ignored):
  - host_str_wr stores at str[str_len] and increments str_len; writes beyond STR_MAX are dropped.
  - host_pat_wr stores at pat[pat_cnt][cur_len]; chars beyond PAT_MAX are dropped. Writes are also dropped when pat_cnt==NPAT.
  - host_pat_end with cur_len>0 (counting a same-cycle write) latches pat_len[pat_cnt]=cur_len, increments pat_cnt, and clears cur_len. With cur_len==0 it is ignored. With pat_cnt==NPAT it is ignored.
  - host_str_wr and host_pat_wr asserted together: string write wins; the pattern write is dropped.
- host_start in IDLE:
  - If str_len==0 or pat_cnt==0: done pulses next cycle and no results are produced.
  - Otherwise busy=1 from the next cycle, with k=0.
- State machine: IDLE -> SEND_STR -> GAP1 -> SEND_PAT -> WAIT -> REPORT -> GAP2 -> (SEND_STR for k+1 | FIN) -> IDLE.
  - SEND_STR: str_len cycles with eng_isstring=1 and eng_chardata=str[i], i=0..str_len-1, contiguous.
  - GAP1: 1 cycle with isstring=ispattern=0 and chardata=0. The engine needs this falling edge.
  - SEND_PAT: pat_len[k] cycles with eng_ispattern=1 and eng_chardata=pat[k][j], contiguous.
  - WAIT: 8-bit counter cleared on entry. eng_valid=1 captures match/index and moves to REPORT. If the counter reaches TIMEOUT first, capture match=0, index=0, timeout=1, and move to REPORT. eng_valid and timeout in the same cycle: eng_valid wins.
  - REPORT: res_valid=1 for exactly 1 cycle with res_id=k. res_index is forced to 0 when res_match=0.
  - GAP2: 1 idle cycle. Then k increments; if k==pat_cnt-1 was just reported, go to FIN.
  - FIN: done=1 for 1 cycle; busy=0; str_len, pat_cnt, cur_len cleared.
- eng_valid outside WAIT is ignored.
- host_start while busy is ignored.
- Engine outputs are 0 in every state except SEND_STR/SEND_PAT.
- Timing: first eng_isstring comes 1 cycle after host_start. Per job, res_valid comes 1 cycle after the accepted eng_valid.

Test Plan:
- Single match: load "ab cd" and pattern "cd"; model engine returns valid=1, match=1, index=3, 4 cycles after ispattern falls. Required: 5 isstring cycles, 1 gap, 2 ispattern cycles; then res_valid with match=1, index=3, id=0; done 2 cycles later (GAP2, then FIN).
- Queue of 3 patterns ("ab", "x", "^c"): engine returns match/no-match/match. Required: three string replays, results id 0,1,2 in order, match=1,0,1; no-match result has index=0; single done pulse.
- Timeout: engine never asserts valid. Required: res_valid exactly TIMEOUT+1 cycles after WAIT entry, with match=0, timeout=1; sequence continues to the next pattern.
- Overflow: 40 str writes and a 10-char pattern. Required: engine sees exactly 32 string chars and 8 pattern chars. A 5th host_pat_end is ignored, and pat_cnt stays 4.
- Empty start: host_start with pat_cnt=0. Required: done on the next cycle, no eng_isstring, no res_valid.
- Reset mid-SEND_PAT. Required: next cycle all outputs are 0 and busy=0; a subsequent start with empty buffers gives an immediate done.
